// File: rtl/counter_if.sv
// counter_if: up/down/mode request lines into the counter and its volume result back out.
//   up, down, mode : requests, driven by the master
//   volume         : current count, driven by the slave
interface counter_if #(parameter int WIDTH = 4);
  logic up;
  logic down;
  logic mode;
  logic [WIDTH-1:0] volume;
  modport master(output up, down, mode, input volume);
  modport slave(input up, down, mode, output volume);
endinterface

// File: rtl/counter.sv
// counter: up/down volume counter with selectable saturating or wrap-around behaviour.
//   clk     : rising-edge clock
//   n_reset : synchronous active-high reset, clears volume to 0
//   bus     : counter_if slave (up, down, mode in; volume out, registered)
module counter #(parameter int WIDTH = 4) (
  input logic clk,
  input logic n_reset,
  counter_if.slave bus
);
  localparam logic [WIDTH-1:0] MAXV = '1;
  logic [WIDTH-1:0] vol, nxt;
  logic inc, dec;
  // Boundaries are found by explicit compares, so the +1/-1 never aliases past MAXV or 0.
  always_comb begin
    inc = bus.up & ~bus.down;
    dec = bus.down & ~bus.up;
    nxt = inc ? ((vol == MAXV) ? (bus.mode ? '0 : MAXV) : vol + 1'b1) :
          dec ? ((vol == '0) ? (bus.mode ? MAXV : '0) : vol - 1'b1) : vol;
  end
  always_ff @(posedge clk) begin
    if (n_reset) vol <= '0;
    else vol <= nxt;
  end
  assign bus.volume = vol;
endmodule

// File: tb/tb_counter.sv
// tb_counter: scoreboard bench for counter; stimulus pushes expected volumes, a monitor pops and compares.
module tb_counter;
  logic clk = 1'b0;
  logic n_reset = 1'b1;
  int checks = 0;
  int fails = 0;
  int popped = 0;
  logic [3:0] exp_q[$];
  counter_if #(.WIDTH(4)) bus();
  counter #(.WIDTH(4)) dut(.clk(clk), .n_reset(n_reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic step(input logic r, input logic u, input logic d, input logic m, input logic [3:0] e);
    @(negedge clk);
    n_reset = r;
    bus.up = u;
    bus.down = d;
    bus.mode = m;
    exp_q.push_back(e);
  endtask
  initial begin
    logic [3:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (bus.volume !== e) begin
          fails++;
          $display("FAIL volume vector %0d: got %0d expected %0d", popped, bus.volume, e);
        end
        popped++;
      end
    end
  end
  initial begin
    bus.up = 1'b1;
    bus.down = 1'b0;
    bus.mode = 1'b0;
    step(1, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    for (int i = 1; i <= 20; i++) step(0, 1, 0, 0, (i > 15) ? 4'd15 : 4'(i));
    for (int i = 1; i <= 20; i++) step(0, 0, 1, 0, (i > 15) ? 4'd0 : 4'(15 - i));
    for (int i = 0; i < 10; i++) step(0, 1, 1, 0, 0);
    for (int i = 0; i < 10; i++) step(0, 1, 1, 1, 0);
    for (int i = 1; i <= 7; i++) step(0, 1, 0, 0, 4'(i));
    for (int i = 0; i < 5; i++) step(0, 1, 1, 0, 7);
    for (int i = 0; i < 5; i++) step(0, 1, 1, 1, 7);
    for (int i = 8; i <= 14; i++) step(0, 1, 0, 1, 4'(i));
    step(0, 1, 0, 1, 15);
    step(0, 1, 0, 1, 0);
    step(0, 1, 0, 1, 1);
    step(0, 0, 1, 1, 0);
    step(0, 0, 1, 1, 15);
    step(0, 0, 1, 1, 14);
    step(1, 0, 0, 0, 0);
    for (int i = 1; i <= 9; i++) step(0, 1, 0, 0, 4'(i));
    step(1, 1, 0, 0, 0);
    step(0, 1, 0, 0, 1);
    for (int i = 2; i <= 15; i++) step(0, 1, 0, 1, 4'(i));
    step(0, 0, 0, 0, 15);
    step(0, 0, 0, 1, 15);
    step(0, 0, 0, 0, 15);
    step(0, 1, 0, 0, 15);
    step(0, 1, 0, 0, 15);
    step(0, 1, 0, 1, 0);
    step(1, 0, 1, 1, 0);
    step(0, 0, 1, 0, 0);
    @(negedge clk);
    bus.up = 1'b0;
    bus.down = 1'b0;
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expected volumes left unchecked, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
